// File: rtl/lenet_batch_sched.sv
// lenet_batch_sched: runs a batch of ROM images through lenet, relocates engine ROM addresses, queues {idx, digit} results.
// Optional LENET_TIMEOUT_EN: bounds each image's wait and records a 4'hF digit plus sticky err on expiry.
module lenet_batch_sched #(
   parameter int ROM_AW      = 14,
   parameter int IMG_WORDS   = 784,
   parameter int RES_DEPTH   = 4,
   parameter int TIMEOUT_CYC = 1048576
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              batch_start,
   input  logic [7:0]        batch_len,
   output logic              busy,
   output logic              batch_done,
   output logic              err,
   output logic              eng_go,
   input  logic              eng_ready,
   input  logic [3:0]        eng_digit,
   input  logic              eng_cena,
   input  logic [9:0]        eng_aa,
   output logic              rom_cena,
   output logic [ROM_AW-1:0] rom_aa,
   output logic              res_valid,
   output logic [11:0]       res_data,
   input  logic              res_pop
);
   localparam int PW = $clog2(RES_DEPTH);
   localparam logic [PW:0] FULL = RES_DEPTH[PW:0];
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, DONE} state_t;
   state_t state;
   logic [7:0] remain, idx;
   logic [ROM_AW-1:0] base;
   logic [3:0] digit;
   logic ready_q, ready_rise, timed_out, push, pop;
   logic [11:0] mem [RES_DEPTH];
   logic [PW-1:0] wp, rp;
   logic [PW:0] count;
   assign ready_rise = eng_ready & ~ready_q;
   assign rom_cena   = eng_cena;
   assign rom_aa     = base + ROM_AW'(eng_aa);
   assign push       = state == STORE;
   assign pop        = res_pop && count != '0;
   assign res_valid  = count != '0;
   assign res_data   = mem[rp];
`ifdef LENET_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tcnt;
   always_ff @(posedge clk)
      tcnt <= (!rst_n || state != WAIT) ? '0 : tcnt + 1'b1;
   assign timed_out = ~ready_rise && tcnt == TW'(TIMEOUT_CYC - 1);
`else
   assign timed_out = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         batch_done <= 1'b0;
         err        <= 1'b0;
         eng_go     <= 1'b0;
         remain     <= '0;
         idx        <= '0;
         base       <= '0;
         digit      <= '0;
         ready_q    <= 1'b0;
      end else begin
         ready_q    <= eng_ready;
         eng_go     <= 1'b0;
         batch_done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= batch_start;
               if (batch_start) begin
                  remain <= batch_len;
                  idx    <= '0;
                  base   <= '0;
                  err    <= 1'b0;
                  state  <= batch_len == 8'd0 ? DONE : ISSUE;
               end
            end
            // a go is only issued once its result has a guaranteed FIFO slot
            ISSUE: if (count != FULL) begin
               eng_go <= 1'b1;
               state  <= WAIT;
            end
            WAIT: if (ready_rise || timed_out) begin
               digit <= timed_out ? 4'hF : eng_digit;
               err   <= err | timed_out;
               state <= STORE;
            end
            STORE: begin
               remain <= remain - 8'd1;
               idx    <= idx + 8'd1;
               base   <= base + ROM_AW'(IMG_WORDS);
               state  <= remain == 8'd1 ? DONE : ISSUE;
            end
            DONE: begin
               batch_done <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk)
      if (push) mem[wp] <= {idx, digit};
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= push ? wp + 1'b1 : wp;
         rp    <= pop ? rp + 1'b1 : rp;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end
endmodule

// File: tb/tb_lenet_batch_sched.sv
// tb_lenet_batch_sched: randomized engine model plus expected-result queue for lenet_batch_sched.
module tb_lenet_batch_sched;
   logic clk = 0, rst_n = 0, batch_start = 0, eng_cena = 1, res_pop = 0;
   logic [7:0] batch_len = 0;
   logic [9:0] eng_aa = 0;
   logic busy, batch_done, err, eng_go, rom_cena, res_valid, eng_ready;
   logic [3:0] eng_digit;
   logic [13:0] rom_aa;
   logic [11:0] res_data;
   logic man = 0, man_ready = 0, mdl_ready = 0;
   logic [3:0] man_digit = 0, mdl_digit = 0;
   int resp_dly = 10, cd = 0, go_cnt = 0, done_cnt = 0, errors = 0, checks = 0;
   logic [3:0] dig_q[$];
   logic [11:0] exp_q[$];

   assign eng_ready = man ? man_ready : mdl_ready;
   assign eng_digit = man ? man_digit : mdl_digit;

   lenet_batch_sched #(.ROM_AW(14), .IMG_WORDS(784), .RES_DEPTH(4), .TIMEOUT_CYC(50)) dut (
      .clk(clk), .rst_n(rst_n), .batch_start(batch_start), .batch_len(batch_len),
      .busy(busy), .batch_done(batch_done), .err(err), .eng_go(eng_go),
      .eng_ready(eng_ready), .eng_digit(eng_digit), .eng_cena(eng_cena), .eng_aa(eng_aa),
      .rom_cena(rom_cena), .rom_aa(rom_aa), .res_valid(res_valid), .res_data(res_data),
      .res_pop(res_pop));

   always #5 clk = ~clk;

   // engine model: drops ready on go, raises it resp_dly cycles later with the next queued digit
   always @(posedge clk) begin
      if (eng_go) begin
         go_cnt    <= go_cnt + 1;
         mdl_ready <= 1'b0;
         cd        <= resp_dly;
      end else if (cd > 0) begin
         cd <= cd - 1;
         if (cd == 1) begin
            mdl_ready <= 1'b1;
            if (dig_q.size() > 0) mdl_digit <= dig_q.pop_front();
         end
      end
      if (batch_done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic start_batch(input int len);
      @(negedge clk);
      batch_start = 1;
      batch_len   = len[7:0];
      @(negedge clk);
      batch_start = 0;
   endtask

   task automatic plan(input int len, input bit fixed, input logic [3:0] d0, d1, d2);
      logic [3:0] d;
      logic [7:0] i8;
      for (int i = 0; i < len; i++) begin
         d  = fixed ? (i == 0 ? d0 : i == 1 ? d1 : d2) : 4'($urandom_range(0, 9));
         i8 = i[7:0];
         dig_q.push_back(d);
         exp_q.push_back({i8, d});
      end
   endtask

   task automatic drain(input int budget, input bit rnd);
      int n = 0;
      logic [11:0] e;
      while ((exp_q.size() > 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
         res_pop = 0;
         if (res_valid && (!rnd || $urandom_range(0, 1) == 1)) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL drain_extra: got %03h exp none", res_data);
            end else begin
               e = exp_q.pop_front();
               if (res_data !== e) begin
                  errors++;
                  $display("FAIL drain_entry: got %03h exp %03h", res_data, e);
               end
            end
            res_pop = 1;
         end
      end
      @(negedge clk);
      res_pop = 0;
      checks++;
      if (n >= budget || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_end: cycles %0d res_valid %b exp empty within %0d", n, res_valid, budget);
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, batch_done, err, eng_go, res_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b exp 00000", {busy, batch_done, err, eng_go, res_valid});
      end
      rst_n = 1;
   endtask

   task automatic test_basic();
      int g0 = go_cnt, d0 = done_cnt;
      resp_dly = 100;
      plan(3, 1, 4'd7, 4'd2, 4'd1);
      start_batch(3);
      @(negedge clk);
      checks++;
      if (eng_go !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_go_timing: go %b busy %b exp 1 1", eng_go, busy);
      end
      @(negedge clk);
      checks++;
      if (eng_go !== 1'b0) begin
         errors++;
         $display("FAIL basic_go_width: got %b exp 0", eng_go);
      end
      drain(2000, 0);
      checks++;
      if (go_cnt - g0 != 3 || done_cnt - d0 != 1 || busy !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL basic_counts: go %0d done %0d busy %b err %b exp 3 1 0 0", go_cnt - g0, done_cnt - d0, busy, err);
      end
   endtask

   task automatic test_zero_len();
      int g0 = go_cnt;
      start_batch(0);
      checks++;
      if (batch_done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL zero_early: done %b busy %b exp 0 1", batch_done, busy);
      end
      @(negedge clk);
      checks++;
      if (batch_done !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL zero_done: done %b busy %b exp 1 1", batch_done, busy);
      end
      @(negedge clk);
      checks++;
      if (batch_done !== 1'b0 || busy !== 1'b0 || go_cnt != g0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_after: done %b busy %b gos %0d valid %b exp 0 0 0 0", batch_done, busy, go_cnt - g0, res_valid);
      end
   endtask

   task automatic test_reloc();
      int g0 = go_cnt, n = 0, ea;
      logic [9:0] aa;
      resp_dly = 40;
      plan(3, 0, 0, 0, 0);
      start_batch(3);
      for (int img = 0; img < 3; img += 2) begin
         while (go_cnt - g0 < img + 1 && n < 500) begin
            @(negedge clk);
            n++;
         end
         for (int k = 0; k < 4; k++) begin
            aa       = (img == 2 && k == 0) ? 10'd5 : 10'($urandom_range(0, 783));
            eng_aa   = aa;
            eng_cena = 1'($urandom);
            #1;
            ea = (img * 784 + int'(aa)) % 16384;
            checks++;
            if (rom_aa !== ea[13:0] || rom_cena !== eng_cena) begin
               errors++;
               $display("FAIL reloc_img%0d: rom_aa %0d cena %b exp %0d %b", img, rom_aa, rom_cena, ea, eng_cena);
            end
         end
      end
      eng_cena = 1;
      drain(2000, 1);
   endtask

   task automatic test_backpressure();
      int g0 = go_cnt;
      logic [11:0] head;
      resp_dly = 10;
      plan(6, 0, 0, 0, 0);
      start_batch(6);
      repeat (200) @(negedge clk);
      head = res_data;
      checks++;
      if (go_cnt - g0 != 4 || busy !== 1'b1 || head !== exp_q[0]) begin
         errors++;
         $display("FAIL bp_stall: gos %0d busy %b head %03h exp 4 1 %03h", go_cnt - g0, busy, head, exp_q[0]);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (res_data !== head || go_cnt - g0 != 4) begin
         errors++;
         $display("FAIL bp_stable: head %03h gos %0d exp %03h 4", res_data, go_cnt - g0, head);
      end
      res_pop = 1;
      void'(exp_q.pop_front());
      @(negedge clk);
      res_pop = 0;
      repeat (5) @(negedge clk);
      checks++;
      if (go_cnt - g0 != 5) begin
         errors++;
         $display("FAIL bp_release: gos %0d exp 5", go_cnt - g0);
      end
      drain(2000, 0);
   endtask

   task automatic test_ready_high();
      man       = 1;
      man_ready = 1;
      start_batch(1);
      repeat (20) @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rh_no_capture: valid %b busy %b exp 0 1", res_valid, busy);
      end
      man_ready = 0;
      repeat (2) @(negedge clk);
      man_digit = 4'd5;
      man_ready = 1;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL rh_early_valid: got %b exp 0", res_valid);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1) begin
         errors++;
         $display("FAIL rh_valid_latency: got %b exp 1", res_valid);
      end
      exp_q.push_back(12'h005);
      drain(100, 0);
      man = 0;
   endtask

   task automatic test_reset_mid_wait();
      resp_dly = 200;
      plan(2, 0, 0, 0, 0);
      start_batch(2);
      repeat (12) @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      checks++;
      if ({busy, batch_done, err, eng_go, res_valid} !== 5'b0) begin
         errors++;
         $display("FAIL mid_reset: got %b exp 00000", {busy, batch_done, err, eng_go, res_valid});
      end
      rst_n = 1;
      repeat (220) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle: busy %b valid %b exp 0 0", busy, res_valid);
      end
      dig_q.delete();
      exp_q.delete();
   endtask

   task automatic test_random();
      int len, d0;
      for (int r = 0; r < 4; r++) begin
         d0       = done_cnt;
         len      = $urandom_range(1, 9);
         resp_dly = $urandom_range(3, 30);
         plan(len, 0, 0, 0, 0);
         start_batch(len);
         drain(4000, 1);
         checks++;
         if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL random_done: pulses %0d exp 1", done_cnt - d0);
         end
      end
   endtask

`ifdef LENET_TIMEOUT_EN
   task automatic test_timeout();
      man       = 1;
      man_ready = 0;
      exp_q.push_back(12'h00F);
      exp_q.push_back(12'h01F);
      start_batch(2);
      drain(500, 0);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_err: got %b exp 1", err);
      end
      man = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_reloc();
      test_backpressure();
      test_ready_high();
      test_reset_mid_wait();
      test_random();
`ifdef LENET_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
